tdi_line_splitter: RTL and testbench

TDI_LINE_SPLITTER -- requirements
Module: tdi_line_splitter

---
 rtl/tdi_pkg.sv | 24 ++
 rtl/tdi_seg_fifo.sv | 67 ++++++
 rtl/tdi_line_splitter.sv | 202 ++++++++++++++++++++
 tb/tb_tdi_line_splitter.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdi_pkg.sv
// ----------------------------------------------------------------------------
// tdi_pkg
// Shared definitions for the TDI line splitter: data width, default segment
// lengths, burst threshold, FIFO depth, segment counter width and the
// line-splitter state enumeration.
// ----------------------------------------------------------------------------
package tdi_pkg;

   localparam int DATA_W          = 512;
   localparam int CH0_LEN_DEF     = 60;
   localparam int CH1_LEN_DEF     = 60;
   localparam int BURST_LINES_DEF = 8;
   localparam int FIFO_DEPTH_DEF  = 1024;
   localparam int SEG_CNT_W       = 16;

   typedef enum logic [2:0] {
      IDLE,
      CH0,
      CH1,
      PAD,
      DROP
   } state_t;

endpackage

// File: rtl/tdi_seg_fifo.sv
// ----------------------------------------------------------------------------
// tdi_seg_fifo
// Synchronous first-word-fall-through FIFO carrying one data beat plus its
// segment-final flag. The head entry is presented combinationally, so a
// written beat is visible on rd_data/empty the cycle after its write.
//
// Ports:
//   clk_300  clock
//   rst      asynchronous active-high reset (empties the FIFO)
//   wr_en    write request (ignored while full)
//   wr_data  beat data to store
//   wr_last  segment-final flag stored with the beat
//   full     no free entry
//   rd_en    pop request (ignored while empty)
//   rd_data  head beat data
//   rd_last  head beat segment-final flag
//   empty    no stored entry
// ----------------------------------------------------------------------------
module tdi_seg_fifo
   import tdi_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF
) (
   input  logic              clk_300,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_last,
   output logic              full,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W:0] mem [DEPTH];
   logic [AW:0]     wr_ptr;
   logic [AW:0]     rd_ptr;
   logic            wr_ok;
   logic            rd_ok;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign wr_ok = wr_en && !full;
   assign rd_ok = rd_en && !empty;

   assign {rd_last, rd_data} = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_300 or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (rd_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage holds data only, so it is left out of reset.
   always_ff @(posedge clk_300) begin
      if (wr_ok) mem[wr_ptr[AW-1:0]] <= {wr_last, wr_data};
   end

endmodule

// File: rtl/tdi_line_splitter.sv
// ----------------------------------------------------------------------------
// tdi_line_splitter
// Splits each incoming TDI line into two fixed-length segments: the first
// CH0_LEN beats go to channel 0, the next CH1_LEN beats to channel 1. Long
// lines are truncated (excess dropped), short lines are zero-padded; both
// raise a one-cycle len_err. Each channel keeps a count of complete segments
// it holds and flags burst_ready once BURST_LINES are buffered.
//
// Ports:
//   clk_300, rst                      clock, asynchronous active-high reset
//   s_axis_tdata/tvalid/tready/tlast  raw line input (AXI-Stream)
//   m_axis_*_0, m_axis_*_1            per-channel segment outputs
//   burst_ready_0/_1                  >= BURST_LINES complete segments held
//   len_err                           one-cycle pulse on line length mismatch
//   seg_cnt_0/_1                      complete segments currently held
// ----------------------------------------------------------------------------
module tdi_line_splitter
   import tdi_pkg::*;
#(
   parameter int CH0_LEN     = CH0_LEN_DEF,
   parameter int CH1_LEN     = CH1_LEN_DEF,
   parameter int BURST_LINES = BURST_LINES_DEF,
   parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
   input  logic                 clk_300,
   input  logic                 rst,
   input  logic [DATA_W-1:0]    s_axis_tdata,
   input  logic                 s_axis_tvalid,
   output logic                 s_axis_tready,
   input  logic                 s_axis_tlast,
   output logic [DATA_W-1:0]    m_axis_tdata_0,
   output logic                 m_axis_tvalid_0,
   input  logic                 m_axis_tready_0,
   output logic                 m_axis_tlast_0,
   output logic [DATA_W-1:0]    m_axis_tdata_1,
   output logic                 m_axis_tvalid_1,
   input  logic                 m_axis_tready_1,
   output logic                 m_axis_tlast_1,
   output logic                 burst_ready_0,
   output logic                 burst_ready_1,
   output logic                 len_err,
   output logic [SEG_CNT_W-1:0] seg_cnt_0,
   output logic [SEG_CNT_W-1:0] seg_cnt_1
);

   localparam int LINE_LEN = CH0_LEN + CH1_LEN;
   localparam int BEAT_W   = $clog2(LINE_LEN);
   localparam logic [BEAT_W-1:0]    SEG0_LAST = BEAT_W'(CH0_LEN - 1);
   localparam logic [BEAT_W-1:0]    LINE_LAST = BEAT_W'(LINE_LEN - 1);
   localparam logic [SEG_CNT_W-1:0] BURST_THR = SEG_CNT_W'(BURST_LINES);

   state_t            state;
   state_t            state_nxt;
   logic [BEAT_W-1:0] beat;
   logic [BEAT_W-1:0] beat_nxt;
   logic              len_err_nxt;
   logic              run;

   logic              dest_ch;
   logic              dest_full;
   logic              seg_last;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              wr_en_0;
   logic              wr_en_1;
   logic              full_0;
   logic              full_1;
   logic              empty_0;
   logic              empty_1;
   logic              rd_0;
   logic              rd_1;

   // Position within the line selects the channel and the segment-final flag.
   assign dest_ch   = (beat > SEG0_LAST);
   assign dest_full = dest_ch ? full_1 : full_0;
   assign seg_last  = (beat == SEG0_LAST) || (beat == LINE_LAST);

   // State register. run holds input ready low for the first cycle out of reset.
   always_ff @(posedge clk_300 or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         beat    <= '0;
         len_err <= 1'b0;
         run     <= 1'b0;
      end else begin
         state   <= state_nxt;
         beat    <= beat_nxt;
         len_err <= len_err_nxt;
         run     <= 1'b1;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      beat_nxt  = beat;
      unique case (state)
         IDLE, CH0, CH1: begin
            if (wr_en) begin
               if (beat == LINE_LAST) begin
                  beat_nxt  = '0;
                  state_nxt = s_axis_tlast ? IDLE : DROP;
               end else begin
                  beat_nxt = beat + BEAT_W'(1);
                  if (s_axis_tlast) state_nxt = PAD;
                  else              state_nxt = (beat_nxt > SEG0_LAST) ? CH1 : CH0;
               end
            end
         end
         PAD: begin
            if (wr_en) begin
               if (beat == LINE_LAST) begin
                  beat_nxt  = '0;
                  state_nxt = IDLE;
               end else begin
                  beat_nxt = beat + BEAT_W'(1);
               end
            end
         end
         DROP: begin
            if (s_axis_tvalid && s_axis_tready && s_axis_tlast) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      len_err_nxt = ((state_nxt == PAD) || (state_nxt == DROP)) &&
                    (state != PAD) && (state != DROP);
   end

   // Output logic: input ready and FIFO write control.
   always_comb begin
      s_axis_tready = 1'b0;
      wr_en         = 1'b0;
      wr_data       = s_axis_tdata;
      unique case (state)
         IDLE, CH0, CH1: begin
            s_axis_tready = run && !dest_full;
            wr_en         = s_axis_tvalid && s_axis_tready;
         end
         PAD: begin
            wr_data = '0;
            wr_en   = !dest_full;
         end
         DROP:    s_axis_tready = run;
         default: s_axis_tready = 1'b0;
      endcase
   end

   assign wr_en_0 = wr_en && !dest_ch;
   assign wr_en_1 = wr_en &&  dest_ch;

   tdi_seg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_0 (
      .clk_300 (clk_300),
      .rst     (rst),
      .wr_en   (wr_en_0),
      .wr_data (wr_data),
      .wr_last (seg_last),
      .full    (full_0),
      .rd_en   (rd_0),
      .rd_data (m_axis_tdata_0),
      .rd_last (m_axis_tlast_0),
      .empty   (empty_0)
   );

   tdi_seg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_1 (
      .clk_300 (clk_300),
      .rst     (rst),
      .wr_en   (wr_en_1),
      .wr_data (wr_data),
      .wr_last (seg_last),
      .full    (full_1),
      .rd_en   (rd_1),
      .rd_data (m_axis_tdata_1),
      .rd_last (m_axis_tlast_1),
      .empty   (empty_1)
   );

   assign m_axis_tvalid_0 = !empty_0;
   assign m_axis_tvalid_1 = !empty_1;
   assign rd_0 = m_axis_tvalid_0 && m_axis_tready_0;
   assign rd_1 = m_axis_tvalid_1 && m_axis_tready_1;

   // Segment counters: +1 on a segment-final write, -1 on an output tlast handshake.
   always_ff @(posedge clk_300 or posedge rst) begin
      if (rst) begin
         seg_cnt_0 <= '0;
         seg_cnt_1 <= '0;
      end else begin
         if ((wr_en_0 && seg_last) && !(rd_0 && m_axis_tlast_0))
            seg_cnt_0 <= seg_cnt_0 + SEG_CNT_W'(1);
         else if (!(wr_en_0 && seg_last) && (rd_0 && m_axis_tlast_0))
            seg_cnt_0 <= seg_cnt_0 - SEG_CNT_W'(1);
         if ((wr_en_1 && seg_last) && !(rd_1 && m_axis_tlast_1))
            seg_cnt_1 <= seg_cnt_1 + SEG_CNT_W'(1);
         else if (!(wr_en_1 && seg_last) && (rd_1 && m_axis_tlast_1))
            seg_cnt_1 <= seg_cnt_1 - SEG_CNT_W'(1);
      end
   end

   assign burst_ready_0 = (seg_cnt_0 >= BURST_THR);
   assign burst_ready_1 = (seg_cnt_1 >= BURST_THR);

endmodule

// File: tb/tb_tdi_line_splitter.sv
// ----------------------------------------------------------------------------
// tb_tdi_line_splitter
// Self-checking bench for tdi_line_splitter with CH0_LEN=CH1_LEN=4,
// BURST_LINES=8, FIFO_DEPTH=64. A line-level reference model predicts the
// beats each channel must emit; output handshakes are collected and compared.
// ----------------------------------------------------------------------------
module tb_tdi_line_splitter;

   localparam int C0  = 4;
   localparam int C1  = 4;
   localparam int BL  = 8;
   localparam int FD  = 64;
   localparam int LL  = C0 + C1;

   typedef logic [512:0] beat_t;   // {last, data}

   logic         clk_300;
   logic         rst;
   logic [511:0] s_data;
   logic         s_valid;
   logic         s_ready;
   logic         s_last;
   logic [511:0] m_data_0, m_data_1;
   logic         m_valid_0, m_valid_1;
   logic         rdy0, rdy1;
   logic         m_last_0, m_last_1;
   logic         burst_0, burst_1;
   logic         len_err;
   logic [15:0]  seg_cnt_0, seg_cnt_1;

   int    checks = 0;
   int    errors = 0;
   int    lerr_cnt = 0;
   int    exp_lerr = 0;
   bit    rand_ready = 0;
   beat_t got [2][$];
   beat_t exp [2][$];
   logic [511:0] line_q [$];

   tdi_line_splitter #(
      .CH0_LEN(C0), .CH1_LEN(C1), .BURST_LINES(BL), .FIFO_DEPTH(FD)
   ) dut (
      .clk_300        (clk_300),
      .rst            (rst),
      .s_axis_tdata   (s_data),
      .s_axis_tvalid  (s_valid),
      .s_axis_tready  (s_ready),
      .s_axis_tlast   (s_last),
      .m_axis_tdata_0 (m_data_0),
      .m_axis_tvalid_0(m_valid_0),
      .m_axis_tready_0(rdy0),
      .m_axis_tlast_0 (m_last_0),
      .m_axis_tdata_1 (m_data_1),
      .m_axis_tvalid_1(m_valid_1),
      .m_axis_tready_1(rdy1),
      .m_axis_tlast_1 (m_last_1),
      .burst_ready_0  (burst_0),
      .burst_ready_1  (burst_1),
      .len_err        (len_err),
      .seg_cnt_0      (seg_cnt_0),
      .seg_cnt_1      (seg_cnt_1)
   );

   initial clk_300 = 1'b0;
   always #5 clk_300 = ~clk_300;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Advance one clock from a falling edge, recording what the upcoming
   // rising edge will transfer on each output channel.
   task automatic tick();
      if (rand_ready) begin
         rdy0 = 1'($urandom_range(0, 1));
         rdy1 = 1'($urandom_range(0, 1));
      end
      if (m_valid_0 && rdy0) got[0].push_back({m_last_0, m_data_0});
      if (m_valid_1 && rdy1) got[1].push_back({m_last_1, m_data_1});
      if (len_err) lerr_cnt++;
      @(negedge clk_300);
   endtask

   task automatic send_beat(input logic [511:0] d, input logic l);
      int guard = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      while (!s_ready && guard < 300) begin
         tick();
         guard++;
      end
      if (guard >= 300) begin
         errors++;
         $display("FAIL input_handshake: tready stayed %b for %0d cycles, required 1", s_ready, guard);
      end else begin
         tick();
      end
      s_valid = 1'b0;
   endtask

   // Reference model: a line of n beats yields exactly C0 beats on channel 0
   // and C1 beats on channel 1; missing beats are zero, extra beats vanish,
   // and the last beat of each segment carries last=1.
   task automatic gen_line(input int n);
      line_q.delete();
      for (int i = 0; i < n; i++) line_q.push_back(rand512());
      for (int i = 0; i < LL; i++) begin
         logic [511:0] d;
         d = (i < n) ? line_q[i] : '0;
         if (i < C0) exp[0].push_back({(i == C0 - 1), d});
         else        exp[1].push_back({(i == LL - 1), d});
      end
      if (n != LL) exp_lerr++;
   endtask

   task automatic send_line(input int n);
      gen_line(n);
      for (int i = 0; i < n; i++) send_beat(line_q[i], (i == n - 1));
   endtask

   task automatic drain(input int cycles);
      rand_ready = 0;
      rdy0 = 1'b1;
      rdy1 = 1'b1;
      repeat (cycles) tick();
   endtask

   task automatic clear_q();
      for (int c = 0; c < 2; c++) begin
         got[c].delete();
         exp[c].delete();
      end
      lerr_cnt = 0;
      exp_lerr = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk_300);
      checks++;
      if ({s_ready, m_valid_0, m_valid_1, burst_0, burst_1, len_err} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got ready,v0,v1,b0,b1,err=%b required 000000",
                  {s_ready, m_valid_0, m_valid_1, burst_0, burst_1, len_err});
      end
      checks++;
      if (seg_cnt_0 !== 16'd0 || seg_cnt_1 !== 16'd0) begin
         errors++;
         $display("FAIL reset_seg_cnt: got %0d/%0d required 0/0", seg_cnt_0, seg_cnt_1);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_normal();
      clear_q();
      rdy0 = 1'b1;
      rdy1 = 1'b1;
      for (int l = 0; l < 8; l++) send_line(LL);
      drain(20);
      for (int c = 0; c < 2; c++) begin
         checks++;
         if (got[c].size() != exp[c].size()) begin
            errors++;
            $display("FAIL normal_count ch%0d: got %0d beats required %0d", c, got[c].size(), exp[c].size());
         end
         for (int i = 0; i < got[c].size() && i < exp[c].size(); i++) begin
            checks++;
            if (got[c][i] !== exp[c][i]) begin
               errors++;
               $display("FAIL normal_beat ch%0d[%0d]: got last=%b data=%h required last=%b data=%h",
                        c, i, got[c][i][512], got[c][i][63:0], exp[c][i][512], exp[c][i][63:0]);
            end
         end
      end
      checks++;
      if (lerr_cnt != 0 || seg_cnt_0 !== 16'd0 || seg_cnt_1 !== 16'd0) begin
         errors++;
         $display("FAIL normal_idle: got len_err=%0d seg=%0d/%0d required 0 0/0", lerr_cnt, seg_cnt_0, seg_cnt_1);
      end
   endtask

   task automatic test_burst();
      int guard;
      clear_q();
      rdy0 = 1'b0;
      rdy1 = 1'b0;
      for (int l = 0; l < 7; l++) send_line(LL);
      gen_line(LL);
      for (int i = 0; i < LL - 1; i++) send_beat(line_q[i], 1'b0);
      checks++;
      if (burst_1 !== 1'b0 || seg_cnt_1 !== 16'd7) begin
         errors++;
         $display("FAIL burst_before: got burst1=%b seg1=%0d required 0 7", burst_1, seg_cnt_1);
      end
      send_beat(line_q[LL-1], 1'b1);
      checks++;
      if (burst_1 !== 1'b1 || seg_cnt_1 !== 16'd8) begin
         errors++;
         $display("FAIL burst_after1: got burst1=%b seg1=%0d required 1 8", burst_1, seg_cnt_1);
      end
      checks++;
      if (burst_0 !== 1'b1 || seg_cnt_0 !== 16'd8) begin
         errors++;
         $display("FAIL burst_after0: got burst0=%b seg0=%0d required 1 8", burst_0, seg_cnt_0);
      end
      rdy1 = 1'b1;
      guard = 0;
      while (got[1].size() < C1 && guard < 50) begin
         tick();
         guard++;
      end
      rdy1 = 1'b0;
      checks++;
      if (burst_1 !== 1'b0 || seg_cnt_1 !== 16'd7 || burst_0 !== 1'b1) begin
         errors++;
         $display("FAIL burst_drain1: got burst1=%b seg1=%0d burst0=%b required 0 7 1", burst_1, seg_cnt_1, burst_0);
      end
      drain(50);
      for (int c = 0; c < 2; c++) begin
         checks++;
         if (got[c].size() != exp[c].size()) begin
            errors++;
            $display("FAIL burst_count ch%0d: got %0d beats required %0d", c, got[c].size(), exp[c].size());
         end
         for (int i = 0; i < got[c].size() && i < exp[c].size(); i++) begin
            checks++;
            if (got[c][i] !== exp[c][i]) begin
               errors++;
               $display("FAIL burst_beat ch%0d[%0d]: got last=%b data=%h required last=%b data=%h",
                        c, i, got[c][i][512], got[c][i][63:0], exp[c][i][512], exp[c][i][63:0]);
            end
         end
      end
   endtask

   task automatic test_length_errors();
      clear_q();
      rdy0 = 1'b1;
      rdy1 = 1'b1;
      send_line(10);
      send_line(LL);
      send_line(6);
      checks++;
      if (s_ready !== 1'b0) begin
         errors++;
         $display("FAIL pad_ready_first: got tready=%b required 0", s_ready);
      end
      tick();
      checks++;
      if (s_ready !== 1'b0) begin
         errors++;
         $display("FAIL pad_ready_second: got tready=%b required 0", s_ready);
      end
      send_line(C0);
      send_line(1);
      send_line(LL);
      drain(30);
      checks++;
      if (lerr_cnt != exp_lerr) begin
         errors++;
         $display("FAIL len_err_pulses: got %0d cycles required %0d", lerr_cnt, exp_lerr);
      end
      for (int c = 0; c < 2; c++) begin
         checks++;
         if (got[c].size() != exp[c].size()) begin
            errors++;
            $display("FAIL lenerr_count ch%0d: got %0d beats required %0d", c, got[c].size(), exp[c].size());
         end
         for (int i = 0; i < got[c].size() && i < exp[c].size(); i++) begin
            checks++;
            if (got[c][i] !== exp[c][i]) begin
               errors++;
               $display("FAIL lenerr_beat ch%0d[%0d]: got last=%b data=%h required last=%b data=%h",
                        c, i, got[c][i][512], got[c][i][63:0], exp[c][i][512], exp[c][i][63:0]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      clear_q();
      rdy0 = 1'b1;
      rdy1 = 1'b0;
      for (int l = 0; l < FD / C1; l++) send_line(LL);
      gen_line(LL);
      for (int i = 0; i < C0; i++) send_beat(line_q[i], 1'b0);
      s_valid = 1'b1;
      s_data  = line_q[C0];
      s_last  = 1'b0;
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready cycle %0d: got tready=%b required 0", k, s_ready);
         end
         tick();
      end
      checks++;
      if (got[0].size() != exp[0].size()) begin
         errors++;
         $display("FAIL bp_ch0_drain: got %0d beats required %0d", got[0].size(), exp[0].size());
      end
      rdy1 = 1'b1;
      for (int i = C0; i < LL; i++) send_beat(line_q[i], (i == LL - 1));
      drain(100);
      for (int c = 0; c < 2; c++) begin
         checks++;
         if (got[c].size() != exp[c].size()) begin
            errors++;
            $display("FAIL bp_count ch%0d: got %0d beats required %0d", c, got[c].size(), exp[c].size());
         end
         for (int i = 0; i < got[c].size() && i < exp[c].size(); i++) begin
            checks++;
            if (got[c][i] !== exp[c][i]) begin
               errors++;
               $display("FAIL bp_beat ch%0d[%0d]: got last=%b data=%h required last=%b data=%h",
                        c, i, got[c][i][512], got[c][i][63:0], exp[c][i][512], exp[c][i][63:0]);
            end
         end
      end
   endtask

   task automatic test_random();
      clear_q();
      rand_ready = 1;
      for (int l = 0; l < 30; l++) send_line($urandom_range(1, 12));
      drain(150);
      checks++;
      if (lerr_cnt != exp_lerr) begin
         errors++;
         $display("FAIL rand_len_err: got %0d pulses required %0d", lerr_cnt, exp_lerr);
      end
      for (int c = 0; c < 2; c++) begin
         checks++;
         if (got[c].size() != exp[c].size()) begin
            errors++;
            $display("FAIL rand_count ch%0d: got %0d beats required %0d", c, got[c].size(), exp[c].size());
         end
         for (int i = 0; i < got[c].size() && i < exp[c].size(); i++) begin
            checks++;
            if (got[c][i] !== exp[c][i]) begin
               errors++;
               $display("FAIL rand_beat ch%0d[%0d]: got last=%b data=%h required last=%b data=%h",
                        c, i, got[c][i][512], got[c][i][63:0], exp[c][i][512], exp[c][i][63:0]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_q();
      rdy0 = 1'b0;
      rdy1 = 1'b0;
      for (int i = 0; i < 5; i++) send_beat(rand512(), 1'b0);
      checks++;
      if (seg_cnt_0 !== 16'd1 || m_valid_1 !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_before: got seg0=%0d v1=%b required 1 1", seg_cnt_0, m_valid_1);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({s_ready, m_valid_0, m_valid_1, burst_0, burst_1, len_err} !== 6'b0 ||
          seg_cnt_0 !== 16'd0 || seg_cnt_1 !== 16'd0) begin
         errors++;
         $display("FAIL rstmid_outputs: got ready,v0,v1,b0,b1,err=%b seg=%0d/%0d required 000000 0/0",
                  {s_ready, m_valid_0, m_valid_1, burst_0, burst_1, len_err}, seg_cnt_0, seg_cnt_1);
      end
      @(negedge clk_300);
      rst = 1'b0;
      clear_q();
      rdy0 = 1'b1;
      rdy1 = 1'b1;
      send_line(LL);
      drain(20);
      checks++;
      if (lerr_cnt != 0) begin
         errors++;
         $display("FAIL rstmid_len_err: got %0d pulses required 0", lerr_cnt);
      end
      for (int c = 0; c < 2; c++) begin
         checks++;
         if (got[c].size() != exp[c].size()) begin
            errors++;
            $display("FAIL rstmid_count ch%0d: got %0d beats required %0d", c, got[c].size(), exp[c].size());
         end
         for (int i = 0; i < got[c].size() && i < exp[c].size(); i++) begin
            checks++;
            if (got[c][i] !== exp[c][i]) begin
               errors++;
               $display("FAIL rstmid_beat ch%0d[%0d]: got last=%b data=%h required last=%b data=%h",
                        c, i, got[c][i][512], got[c][i][63:0], exp[c][i][512], exp[c][i][63:0]);
            end
         end
      end
   endtask

   initial begin
      rst     = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      rdy0    = 1'b0;
      rdy1    = 1'b0;
      test_reset();
      test_normal();
      test_burst();
      test_length_errors();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
